// File: rtl/hw_accel_pkg.sv
// Shared definitions for the TinyML pre-processing frame controller.
// State encodings stay plain constants so legacy register maps can decode them.
package hw_accel_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  localparam int OUT_WORDS_DEF = 2304;
  localparam int FLUSH_CYCLES  = 2;

endpackage

// File: rtl/hw_accel_sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module hw_accel_sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hw_accel_frame_ctrl.sv
// Frame sequencer: admits one input frame per start, counts packed output words,
// and flushes the accelerator pipeline on abort or drain timeout.
module hw_accel_frame_ctrl
  import hw_accel_pkg::*;
#(
  parameter int FRAME_WIDTH    = 540,
  parameter int FRAME_HEIGHT   = 540,
  parameter int OUT_WORDS      = OUT_WORDS_DEF,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_start,
  input  logic             ctrl_abort,
  output logic             ctrl_busy,
  output logic             ctrl_done,
  output logic             ctrl_irq,
  output logic             ctrl_err_timeout,
  output logic [15:0]      ctrl_drop_cnt,
  input  logic             src_pixel_valid,
  output logic             src_pixel_ready,
  output logic             accel_in_valid,
  input  logic             accel_out_valid,
  output logic             accel_flush,
  output logic [CNT_W-1:0] in_pix_cnt,
  output logic [11:0]      out_word_cnt
);

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_WIDTH * FRAME_HEIGHT - 1);
  localparam logic [11:0]      OUT_MAX  = 12'(OUT_WORDS);
  localparam logic [11:0]      OUT_LAST = 12'(OUT_WORDS - 1);

  logic [2:0]      state;
  logic [TO_W-1:0] timer;
  logic [1:0]      flush_cnt;
  logic            accept;
  logic            start_ok;
  logic            word_in;
  logic            words_done;

  assign src_pixel_ready = (state == ST_RUN);
  assign accept          = src_pixel_valid & src_pixel_ready;
  assign accel_in_valid  = accept;
  assign start_ok        = ctrl_start & ((state == ST_IDLE) || (state == ST_DONE));
  assign word_in         = accel_out_valid & ((state == ST_RUN) || (state == ST_DRAIN));
  // Look ahead at the incoming word so done rises one cycle after the last word.
  assign words_done      = (out_word_cnt == OUT_MAX) || (word_in && (out_word_cnt == OUT_LAST));

  assign ctrl_busy   = (state == ST_RUN) || (state == ST_DRAIN);
  assign ctrl_done   = (state == ST_DONE);
  assign accel_flush = rst || (state == ST_FLUSH);

  hw_accel_sat_counter #(.W(16), .MAX(16'hFFFF)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (src_pixel_valid && (state != ST_RUN)),
    .cnt (ctrl_drop_cnt)
  );

  hw_accel_sat_counter #(.W(12), .MAX(OUT_MAX)) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .inc (word_in),
    .cnt (out_word_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      in_pix_cnt       <= '0;
      timer            <= '0;
      flush_cnt        <= '0;
      ctrl_irq         <= 1'b0;
      ctrl_err_timeout <= 1'b0;
    end else begin
      ctrl_irq <= 1'b0;
      if (accept) begin
        in_pix_cnt <= in_pix_cnt + CNT_W'(1);
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state            <= ST_RUN;
            in_pix_cnt       <= '0;
            ctrl_err_timeout <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ctrl_abort) begin
            state     <= ST_FLUSH;
            flush_cnt <= 2'(FLUSH_CYCLES - 1);
          end else if (accept && (in_pix_cnt == LAST_PIX)) begin
            state <= ST_DRAIN;
            timer <= TO_LOAD;
          end
        end
        ST_DRAIN: begin
          if (ctrl_abort) begin
            state     <= ST_FLUSH;
            flush_cnt <= 2'(FLUSH_CYCLES - 1);
          end else if (words_done) begin
            state    <= ST_DONE;
            ctrl_irq <= 1'b1;
          end else if (word_in) begin
            timer <= TO_LOAD;
          end else if (timer == TO_W'(1)) begin
            state            <= ST_FLUSH;
            flush_cnt        <= 2'(FLUSH_CYCLES - 1);
            ctrl_err_timeout <= 1'b1;
            ctrl_irq         <= 1'b1;
          end else begin
            timer <= timer - TO_W'(1);
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 2'd0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
